// File: rtl/dmem_lsu.sv
// Load/store unit bridging the single-cycle datapath memory port to a word-wide
// request/acknowledge data memory, with byte-lane steering and a bus timeout.
module dmem_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              half,
  input  logic              b,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       readdata,
  output logic              stall,
  output logic              misalign,
  output logic              buserr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam bit          USE_TO  = (TIMEOUT != 0);
  localparam logic [31:0] CNT_MAX = 32'(TIMEOUT - 1);

  state_t      state, next_state;
  logic [31:0] cnt;
  logic [31:0] rdata_q;
  logic        err;
  logic        access, is_load, mis, expire;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  // Sign-extend the addressed lane of a memory word for byte/halfword loads.
  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] lane,
                                           input logic sz_b, input logic sz_h);
    logic [7:0]  by;
    logic [15:0] hw;
    case (lane)
      2'd0:    by = w[7:0];
      2'd1:    by = w[15:8];
      2'd2:    by = w[23:16];
      2'd3:    by = w[31:24];
      default: by = 8'h00;
    endcase
    hw = lane[1] ? w[31:16] : w[15:0];
    if (sz_b)      return {{24{by[7]}}, by};
    else if (sz_h) return {{16{hw[15]}}, hw};
    else           return w;
  endfunction

  assign access  = memread | memwrite;
  assign is_load = memread & ~memwrite;
  assign mis     = ~b & (half ? addr[0] : (addr[1:0] != 2'b00));
  assign expire  = USE_TO && (cnt == CNT_MAX);
  assign buserr  = err;

  // Byte enables and lane-replicated store data for the requested size.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    if (b) begin
      be_c    = 4'b0001 << addr[1:0];
      wdata_c = {4{wdata[7:0]}};
    end else if (half) begin
      be_c    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{wdata[15:0]}};
    end else begin
      be_c    = 4'b1111;
      wdata_c = wdata;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; an ack coinciding with expiry wins as a success.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = (access && !mis) ? BUSY : IDLE;
      BUSY:    next_state = (mem_ack || expire) ? DONE : BUSY;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Core-facing outputs; stall and misalign are forced low during reset.
  always_comb begin
    stall    = 1'b0;
    misalign = 1'b0;
    readdata = 32'h0000_0000;
    if (reset) begin
      stall    = 1'b0;
      misalign = 1'b0;
      readdata = 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          stall    = access & ~mis;
          misalign = access & mis;
        end
        BUSY:    stall = 1'b1;
        DONE:    readdata = is_load ? fmt_load(rdata_q, addr[1:0], b, half) : 32'h0000_0000;
        default: stall = 1'b0;
      endcase
    end
  end

  // Memory request registers, timeout counter, captured load word and error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
      cnt       <= 32'd0;
      rdata_q   <= 32'h0000_0000;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 32'd0;
          if (access && !mis) begin
            mem_req   <= 1'b1;
            mem_we    <= memwrite;
            mem_addr  <= addr[ADDR_W-1:2];
            mem_be    <= be_c;
            mem_wdata <= wdata_c;
          end
        end
        BUSY: begin
          cnt <= cnt + 32'd1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (is_load) rdata_q <= mem_rdata;
          end else if (expire) begin
            mem_req <= 1'b0;
            rdata_q <= 32'h0000_0000;
            err     <= 1'b1;
          end
        end
        DONE:    err <= 1'b0;
        default: mem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with TIMEOUT=4.
module tb_dmem_lsu;
  logic        clk, reset, memread, memwrite, half, b;
  logic [31:0] addr, wdata, readdata, mem_wdata, mem_rdata;
  logic        stall, misalign, buserr, mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;

  int tests = 0;
  int fails = 0;

  int          stalls, busy_cyc;
  logic        done_ok, err_done, mis_done, unstable, we_s;
  logic [31:0] rd_done, wd_s;
  logic [29:0] a_s;
  logic [3:0]  be_s;

  dmem_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite), .half(half), .b(b),
    .addr(addr), .wdata(wdata), .readdata(readdata), .stall(stall), .misalign(misalign),
    .buserr(buserr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic rd, input logic wr, input logic h, input logic bb,
                        input logic [31:0] a, input logic [31:0] wd);
    memread = rd; memwrite = wr; half = h; b = bb; addr = a; wdata = wd;
  endtask

  // Memory responder: acks in BUSY cycle n_wait+1; records what the DUT presented.
  task automatic run_access(input int n_wait, input logic ack_en, input logic [31:0] rd);
    stalls = 0; busy_cyc = 0; done_ok = 1'b0; unstable = 1'b0;
    rd_done = 32'hx; err_done = 1'bx; mis_done = 1'bx;
    for (int i = 0; i < 40 && !done_ok; i++) begin
      #1;
      if (stall) stalls++;
      if (mem_req) begin
        busy_cyc++;
        if (busy_cyc == 1) begin
          a_s = mem_addr; be_s = mem_be; wd_s = mem_wdata; we_s = mem_we;
        end else if (mem_addr !== a_s || mem_be !== be_s || mem_wdata !== wd_s || mem_we !== we_s) begin
          unstable = 1'b1;
        end
        mem_ack   = ack_en && (busy_cyc == n_wait + 1);
        mem_rdata = rd;
      end else begin
        mem_ack = 1'b0;
        if (!stall) begin
          done_ok = 1'b1; rd_done = readdata; err_done = buserr; mis_done = misalign;
        end
      end
      @(negedge clk);
    end
    mem_ack = 1'b0; memread = 1'b0; memwrite = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b exp 0", stall); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b exp 0", mem_req); end
    tests++; if ({readdata, buserr, mem_we, mem_addr, mem_be, mem_wdata} !== 100'd0) begin
      fails++; $display("FAIL rst_outs: got %h %b %b %h %h %h exp all 0", readdata, buserr, mem_we, mem_addr, mem_be, mem_wdata);
    end
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h101, 32'h0);
    #1;
    tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL rst_misalign: got %b exp 0", misalign); end
    @(negedge clk);
    reset = 1'b0; memread = 1'b0;
  endtask

  task automatic test_word_load;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    #1;
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL wl_idle_rd: got %h exp 0", readdata); end
    run_access(2, 1'b1, 32'hDEADBEEF);
    tests++; if (!done_ok) begin fails++; $display("FAIL wl_done: got 0 exp 1"); end
    tests++; if (a_s !== 30'h40) begin fails++; $display("FAIL wl_addr: got %h exp 40", a_s); end
    tests++; if (be_s !== 4'b1111) begin fails++; $display("FAIL wl_be: got %b exp 1111", be_s); end
    tests++; if (we_s !== 1'b0) begin fails++; $display("FAIL wl_we: got %b exp 0", we_s); end
    tests++; if (stalls !== 4) begin fails++; $display("FAIL wl_stalls: got %0d exp 4", stalls); end
    tests++; if (busy_cyc !== 3) begin fails++; $display("FAIL wl_busy: got %0d exp 3", busy_cyc); end
    tests++; if (rd_done !== 32'hDEADBEEF) begin fails++; $display("FAIL wl_rdata: got %h exp deadbeef", rd_done); end
    tests++; if (err_done !== 1'b0) begin fails++; $display("FAIL wl_buserr: got %b exp 0", err_done); end
    tests++; if (unstable !== 1'b0) begin fails++; $display("FAIL wl_stable: got %b exp 0", unstable); end
  endtask

  task automatic test_loads;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h103, 32'h0);
    run_access(0, 1'b1, 32'h80FF0012);
    tests++; if (be_s !== 4'b1000) begin fails++; $display("FAIL bl_be: got %b exp 1000", be_s); end
    tests++; if (rd_done !== 32'hFFFFFF80) begin fails++; $display("FAIL bl_rdata: got %h exp ffffff80", rd_done); end
    tests++; if (stalls !== 2) begin fails++; $display("FAIL bl_stalls: got %0d exp 2", stalls); end
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h102, 32'h0);
    run_access(1, 1'b1, 32'h7FFF8000);
    tests++; if (be_s !== 4'b1100) begin fails++; $display("FAIL hl_be: got %b exp 1100", be_s); end
    tests++; if (rd_done !== 32'h00007FFF) begin fails++; $display("FAIL hl_rdata: got %h exp 00007fff", rd_done); end
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    run_access(0, 1'b1, 32'h7FFF8000);
    tests++; if (be_s !== 4'b0011) begin fails++; $display("FAIL hl0_be: got %b exp 0011", be_s); end
    tests++; if (rd_done !== 32'hFFFF8000) begin fails++; $display("FAIL hl0_rdata: got %h exp ffff8000", rd_done); end
  endtask

  task automatic test_stores;
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h101, 32'h000000AB);
    run_access(0, 1'b1, 32'h0);
    tests++; if (be_s !== 4'b0010) begin fails++; $display("FAIL bs_be: got %b exp 0010", be_s); end
    tests++; if (wd_s !== 32'hABABABAB) begin fails++; $display("FAIL bs_wdata: got %h exp abababab", wd_s); end
    tests++; if (we_s !== 1'b1) begin fails++; $display("FAIL bs_we: got %b exp 1", we_s); end
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h102, 32'h00001234);
    run_access(0, 1'b1, 32'h0);
    tests++; if (be_s !== 4'b1100) begin fails++; $display("FAIL hs_be: got %b exp 1100", be_s); end
    tests++; if (wd_s !== 32'h12341234) begin fails++; $display("FAIL hs_wdata: got %h exp 12341234", wd_s); end
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h104, 32'hCAFEF00D);
    run_access(0, 1'b1, 32'h11111111);
    tests++; if (we_s !== 1'b1 || a_s !== 30'h41) begin fails++; $display("FAIL rw_we_addr: got %b %h exp 1 41", we_s, a_s); end
    tests++; if (wd_s !== 32'hCAFEF00D) begin fails++; $display("FAIL rw_wdata: got %h exp cafef00d", wd_s); end
    tests++; if (rd_done !== 32'h0) begin fails++; $display("FAIL rw_rdata: got %h exp 0", rd_done); end
  endtask

  task automatic test_misalign;
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h101, 32'h0);
    run_access(0, 1'b1, 32'h55555555);
    tests++; if (mis_done !== 1'b1) begin fails++; $display("FAIL mh_misalign: got %b exp 1", mis_done); end
    tests++; if (stalls !== 0 || busy_cyc !== 0) begin fails++; $display("FAIL mh_nomem: got stall %0d req %0d exp 0 0", stalls, busy_cyc); end
    tests++; if (rd_done !== 32'h0) begin fails++; $display("FAIL mh_rdata: got %h exp 0", rd_done); end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h102, 32'h0);
    run_access(0, 1'b1, 32'h55555555);
    tests++; if (mis_done !== 1'b1) begin fails++; $display("FAIL mw_misalign: got %b exp 1", mis_done); end
    tests++; if (stalls !== 0 || busy_cyc !== 0) begin fails++; $display("FAIL mw_nomem: got stall %0d req %0d exp 0 0", stalls, busy_cyc); end
  endtask

  task automatic test_timeout;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    run_access(0, 1'b0, 32'h0);
    tests++; if (busy_cyc !== 4) begin fails++; $display("FAIL to_req: got %0d exp 4", busy_cyc); end
    tests++; if (stalls !== 5) begin fails++; $display("FAIL to_stalls: got %0d exp 5", stalls); end
    tests++; if (err_done !== 1'b1) begin fails++; $display("FAIL to_buserr: got %b exp 1", err_done); end
    tests++; if (rd_done !== 32'h0) begin fails++; $display("FAIL to_rdata: got %h exp 0", rd_done); end
    #1;
    tests++; if (buserr !== 1'b0) begin fails++; $display("FAIL to_clear: got %b exp 0", buserr); end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    run_access(3, 1'b1, 32'h0BADF00D);
    tests++; if (err_done !== 1'b0 || busy_cyc !== 4) begin fails++; $display("FAIL edge_ack: got err %b busy %0d exp 0 4", err_done, busy_cyc); end
    tests++; if (rd_done !== 32'h0BADF00D) begin fails++; $display("FAIL edge_rdata: got %h exp 0badf00d", rd_done); end
  endtask

  task automatic test_reset_mid_busy;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    #1;
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rb_busy: got %b exp 1", mem_req); end
    reset = 1'b1;
    #1;
    tests++; if (mem_req !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL rb_drop: got req %b stall %b exp 0 0", mem_req, stall); end
    @(negedge clk);
    reset = 1'b0; memread = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    tests++; if ({mem_req, stall, buserr, readdata} !== 35'd0) begin
      fails++; $display("FAIL rb_stray: got req %b stall %b err %b rd %h exp 0", mem_req, stall, buserr, readdata);
    end
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h108, 32'h0);
    run_access(0, 1'b1, 32'h01234567);
    tests++; if (rd_done !== 32'h01234567 || a_s !== 30'h42) begin fails++; $display("FAIL rb_after: got %h %h exp 01234567 42", rd_done, a_s); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
